// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and framing constants for the boot loader
package imem_loader_pkg;

  // ST_LEN_CHK is the one-cycle gap after the length bytes where N is range-checked.
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_LEN_CHK,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_BYTES = 2;

  function automatic logic takes_bytes(input state_t s);
    return s inside {ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// rtl/imem_loader_byte_word_packer.sv - packs little-endian bytes into 32-bit words
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        last_lane,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] low;

  assign last_lane = (lane == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      lane       <= 2'd0;
      low        <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: low[7:0]   <= byte_data;
          2'd1: low[15:8]  <= byte_data;
          2'd2: low[23:16] <= byte_data;
          default: begin
            // word only changes here, so it stays stable through the strobe
            word       <= {byte_data, low};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream boot loader holding the CPU until the image verifies
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam int MAX_WORDS = 1 << ADDR_WIDTH;

  state_t                 state, state_next;
  logic [8*LEN_BYTES-1:0] len;
  logic [7:0]             csum;
  logic                   accept;
  logic                   last_lane;
  logic                   last_word;

  assign bus.rx_ready = !reset && takes_bytes(state);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign last_word    = (int'(words_loaded) + 1 == int'(len));

  assign cpu_hold = (state != ST_DONE);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign busy     = state inside {ST_LEN_LO, ST_LEN_HI, ST_LEN_CHK, ST_DATA, ST_CSUM};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SYNC:    if (accept && bus.rx_data == SYNC_BYTE) state_next = ST_LEN_LO;
      ST_LEN_LO:  if (accept) state_next = ST_LEN_HI;
      ST_LEN_HI:  if (accept) state_next = ST_LEN_CHK;
      ST_LEN_CHK: begin
        if (int'(len) > MAX_WORDS) state_next = ST_ERROR;
        else if (len == '0)        state_next = ST_CSUM;
        else                       state_next = ST_DATA;
      end
      ST_DATA:    if (accept && last_lane && last_word) state_next = ST_CSUM;
      ST_CSUM:    if (accept) state_next = (bus.rx_data == csum) ? ST_DONE : ST_ERROR;
      default:    state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len           <= '0;
      csum          <= 8'd0;
      words_loaded  <= '0;
      bus.imem_addr <= '0;
    end else if (accept) begin
      if (state == ST_LEN_LO) len[7:0]  <= bus.rx_data;
      if (state == ST_LEN_HI) len[15:8] <= bus.rx_data;
      if (state == ST_DATA) begin
        csum <= csum ^ bus.rx_data;
        // address is latched alongside the packer's word so both appear with imem_we
        if (last_lane) begin
          bus.imem_addr <= words_loaded[ADDR_WIDTH-1:0];
          words_loaded  <= words_loaded + 1'b1;
        end
      end
    end
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (bus.rx_data),
    .byte_valid (accept && state == ST_DATA),
    .last_lane  (last_lane),
    .word       (bus.imem_wdata),
    .word_valid (bus.imem_we)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed frames against imem_loader with hand-computed expectations
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_hold, busy, done, error;
  logic [8:0] words_loaded;
  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  bit         gaps = 1'b0;

  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // XOR of the twelve data bytes below is 0x93
  logic [7:0]  prog[$] = '{8'hA5, 8'h03, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00,
                           8'h13, 8'h01, 8'h10, 8'h00,
                           8'hB3, 8'h81, 8'h20, 8'h00};
  logic [31:0] exp_data[3] = '{32'h00100093, 32'h00100113, 32'h002081B3};

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  always @(posedge clk) begin
    if (bus.rx_valid && bus.rx_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries;
    if (gaps) begin
      while ($urandom_range(1, 0) == 0) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tries = 0;
    while (!bus.rx_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    check("rx_ready_wait", 64'(tries < 20), 64'd1);
    if (tries < 20) @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_imem_we", bus.imem_we, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    #1;
    check("rx_ready_after_rst", bus.rx_ready, 1);
  endtask

  task automatic check_prog(input string tag);
    check({tag, "_wr_count"}, wr_addr_q.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr_q[i], i);
      check({tag, "_wr_data"}, wr_data_q[i], exp_data[i]);
    end
  endtask

  initial begin
    int acc_before;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);

    do_reset();
    send_bytes(prog);
    check("ok_done_early", done, 0);
    send_byte(8'h93);
    check("ok_done", done, 1);
    check("ok_cpu_hold", cpu_hold, 0);
    check("ok_error", error, 0);
    check("ok_words", words_loaded, 3);
    check("ok_rx_ready", bus.rx_ready, 0);
    check("ok_busy", busy, 0);
    check_prog("ok");

    do_reset();
    send_bytes(prog);
    send_byte(8'h41);
    check("badcs_error", error, 1);
    check("badcs_done", done, 0);
    check("badcs_cpu_hold", cpu_hold, 1);
    check("badcs_rx_ready", bus.rx_ready, 0);
    check_prog("badcs");

    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h00});
    check("zero_done_early", done, 0);
    send_byte(8'h00);
    check("zero_done", done, 1);
    check("zero_cpu_hold", cpu_hold, 0);
    check("zero_writes", wr_addr_q.size(), 0);

    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h01});
    check("zero_bad_error", error, 1);
    check("zero_bad_done", done, 0);

    do_reset();
    send_bytes('{8'hA5, 8'h01, 8'h01});
    acc_before = acc_cnt;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("ovf_error", error, 1);
    check("ovf_no_accept", acc_cnt - acc_before, 0);
    check("ovf_writes", wr_addr_q.size(), 0);
    check("ovf_cpu_hold", cpu_hold, 1);

    do_reset();
    gaps = 1'b1;
    send_bytes('{8'h00, 8'hFF, 8'h5A});
    check("junk_busy", busy, 0);
    send_bytes(prog);
    send_byte(8'h93);
    gaps = 1'b0;
    check("bp_done", done, 1);
    check("bp_cpu_hold", cpu_hold, 0);
    check("bp_words", words_loaded, 3);
    check_prog("bp");

    do_reset();
    send_bytes('{8'hA5, 8'h03, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01});
    check("mid_busy", busy, 1);
    check("mid_words", words_loaded, 1);
    do_reset();
    send_bytes(prog);
    send_byte(8'h93);
    check("reload_done", done, 1);
    check("reload_words", words_loaded, 3);
    check_prog("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
